pio_edge_irq: RTL and testbench

- Parametrised Avalon-MM general-purpose I/O slave. It is the successor to the team's fixed 1-bit, input-only PIO.
- Adds:
  - configurable width
  - per-bit direction control
  - an input synchroniser
  - edge capture with write-1-to-clear
  - a maskable, registered interrupt
- Sits on the SoC system bus between the Nios II interconnect and board switches, keys and LEDs.

---
 rtl/pio_edge_irq_pkg.sv | 12 +
 rtl/pio_sync_bus.sv | 16 +
 rtl/pio_edge_irq.sv | 77 +++++++
 tb/tb_pio_edge_irq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pio_edge_irq_pkg.sv
// pio_edge_irq_pkg: register map and mode encodings shared by the PIO slave.
package pio_edge_irq_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;
endpackage

// File: rtl/pio_sync_bus.sv
// pio_sync_bus: multi-stage synchroniser for a bus of asynchronous inputs.
module pio_sync_bus #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pio_edge_irq.sv
// pio_edge_irq: Avalon-MM GPIO slave with direction, edge capture and maskable irq.
module pio_edge_irq
  import pio_edge_irq_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter int               IRQ_TYPE    = 1,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);
  logic [WIDTH-1:0] data_in, dout_q, dir_q, mask_q, edge_q, edge_d, prev_q;
  logic [WIDTH-1:0] wdata, rise, fall, edge_det, clr, rd_sel;
  logic [31:0]      rd_q, rd_d;
  logic [2:0]       cnt_q;
  logic             armed_q, irq_q, irq_d, wr, unused_wd;

  pio_sync_bus #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .d_i(in_port), .q_o(data_in)
  );

  always_comb begin
    wr       = chipselect & ~write_n;
    wdata    = writedata[WIDTH-1:0];
    rise     = data_in & ~prev_q;
    fall     = ~data_in & prev_q;
    // Edges are suppressed until the synchroniser has flushed after reset.
    edge_det = !armed_q ? '0 : EDGE_TYPE == EDGE_RISE ? rise :
               EDGE_TYPE == EDGE_FALL ? fall : rise | fall;
    clr      = (wr && address == ADDR_EDGE) ? wdata : '0;
    edge_d   = (edge_q & ~clr) | edge_det;
    irq_d    = IRQ_TYPE == IRQ_EDGE ? |(mask_q & edge_q) : |(mask_q & data_in);
    rd_sel   = address == ADDR_DATA ? data_in : address == ADDR_DIR ? dir_q :
               address == ADDR_MASK ? mask_q : edge_q;
    rd_d     = 32'(rd_sel);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_q    <= '0;
      irq_q   <= 1'b0;
      dout_q  <= RESET_OUT;
      dir_q   <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      irq_q   <= irq_d;
      edge_q  <= edge_d;
      prev_q  <= data_in;
      armed_q <= armed_q | (cnt_q == 3'(SYNC_STAGES));
      if (!armed_q) cnt_q <= cnt_q + 3'd1;
      if (wr && address == ADDR_DATA) dout_q <= wdata;
      if (wr && address == ADDR_DIR) dir_q <= wdata;
      if (wr && address == ADDR_MASK) mask_q <= wdata;
    end

  assign unused_wd = ^writedata;
  assign readdata  = rd_q;
  assign irq       = irq_q;
  assign out_port  = dout_q;
  assign out_en    = dir_q;
endmodule

// File: tb/tb_pio_edge_irq.sv
// tb_pio_edge_irq: two configurations (rise/edge-irq and any/level-irq) against a sample-history model.
module tb_pio_edge_irq;
  localparam int S = 2;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = 8'hFF;
  logic [31:0] rd0, rd1;
  logic [7:0]  op0, op1, oe0, oe1;
  logic        irq0, irq1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pio_edge_irq #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0), .IRQ_TYPE(1), .RESET_OUT(8'h00)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in_port), .out_port(op0), .out_en(oe0), .irq(irq0)
  );
  pio_edge_irq #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(2), .IRQ_TYPE(0), .RESET_OUT(8'h5A)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .in_port(in_port), .out_port(op1), .out_en(oe1), .irq(irq1)
  );

  // Model: smp[i] is in_port sampled at clock edge i+1 since reset release.
  int          e;
  logic [7:0]  smp[$];
  logic [7:0]  m_dout[2], m_ec[2];
  logic [7:0]  m_dir, m_mask;
  logic        m_irq[2];
  logic [31:0] m_rd[2];

  function automatic logic [7:0] din(int n);
    return n >= S ? smp[n-S] : 8'h00;
  endfunction

  function automatic logic [7:0] edg(int t, logic [7:0] c, logic [7:0] p);
    return t == 0 ? (c & ~p) : t == 1 ? (~c & p) : (c ^ p);
  endfunction

  wire wr = chipselect && !write_n;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e <= 0;
      smp.delete();
      m_dout[0] <= 8'h00;
      m_dout[1] <= 8'h5A;
      m_dir <= 8'h00;
      m_mask <= 8'h00;
      for (int k = 0; k < 2; k++) begin
        m_ec[k] <= 8'h00;
        m_irq[k] <= 1'b0;
        m_rd[k] <= 32'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_rd[k] <= {24'h0, address == 0 ? din(e) : address == 1 ? m_dir : address == 2 ? m_mask : m_ec[k]};
        m_irq[k] <= k == 0 ? |(m_mask & m_ec[k]) : |(m_mask & din(e));
        m_ec[k] <= (m_ec[k] & ~((wr && address == 3) ? writedata[7:0] : 8'h00)) |
                   (e >= S + 1 ? edg(k == 0 ? 0 : 2, din(e), din(e-1)) : 8'h00);
        if (wr && address == 0) m_dout[k] <= writedata[7:0];
      end
      if (wr && address == 1) m_dir <= writedata[7:0];
      if (wr && address == 2) m_mask <= writedata[7:0];
      smp.push_back(in_port);
      e <= e + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd0", rd0, m_rd[0]);
    chk("rd1", rd1, m_rd[1]);
    chk("out_port0", {24'h0, op0}, {24'h0, m_dout[0]});
    chk("out_port1", {24'h0, op1}, {24'h0, m_dout[1]});
    chk("out_en0", {24'h0, oe0}, {24'h0, m_dir});
    chk("out_en1", {24'h0, oe1}, {24'h0, m_dir});
    chk("irq0", {31'h0, irq0}, {31'h0, m_irq[0]});
    chk("irq1", {31'h0, irq1}, {31'h0, m_irq[1]});
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n = 1'b0;
    address = a;
    writedata = d;
    cyc(1);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rd", rd0, 32'h0);
    chk("reset_out0", {24'h0, op0}, 32'h00);
    chk("reset_out1", {24'h0, op1}, 32'h5A);
    chk("reset_oe", {24'h0, oe0}, 32'h0);
    chk("reset_irq", {31'h0, irq0 | irq1}, 32'h0);
    reset_n = 1'b1;
    cyc(10);
    address = 2'd3;
    cyc(1);
    chk("armed_no_edge", rd0, 32'h0);
    chk("armed_irq", {31'h0, irq0}, 32'h0);
    address = 2'd0;
    cyc(1);
    chk("data_in_ff", rd0, 32'hFF);

    bus_wr(2'd0, 32'hA5);
    bus_wr(2'd1, 32'h0F);
    chk("dout_a5", {24'h0, op0}, 32'hA5);
    chk("dir_0f", {24'h0, oe0}, 32'h0F);
    cyc(1);
    chk("read_dir", rd0, 32'h0F);
    bus_wr(2'd1, 32'hFFFFFF00);
    cyc(1);
    chk("dir_upper_dropped", rd0, 32'h0);

    in_port = 8'h00;
    cyc(4);
    bus_wr(2'd2, 32'h01);
    address = 2'd3;
    in_port = 8'h01;
    cyc(3);
    chk("irq_not_yet", {31'h0, irq0}, 32'h0);
    cyc(1);
    chk("irq_rise", {31'h0, irq0}, 32'h1);
    chk("ec_bit0", rd0, 32'h01);
    in_port = 8'h03;
    cyc(4);
    chk("ec_bit1_masked", rd0, 32'h03);

    bus_wr(2'd3, 32'h01);
    cyc(1);
    chk("w1c", rd0, 32'h02);
    chk("w1c_irq_drop", {31'h0, irq0}, 32'h0);
    in_port = 8'h02;
    cyc(4);
    in_port = 8'h03;
    cyc(2);
    bus_wr(2'd3, 32'h01);
    cyc(1);
    chk("w1c_collision", rd0, 32'h03);

    bus_wr(2'd2, 32'h80);
    in_port = 8'h83;
    cyc(4);
    chk("level_irq_high", {31'h0, irq1}, 32'h1);
    bus_wr(2'd3, 32'hFF);
    cyc(1);
    chk("ec1_cleared", rd1, 32'h0);
    in_port = 8'h03;
    cyc(4);
    chk("fall_any", rd1, 32'h80);
    chk("fall_ignored_rise", rd0, 32'h0);
    chk("level_irq_low", {31'h0, irq1}, 32'h0);

    in_port = 8'h00;
    cyc(4);
    in_port = 8'hFF;
    cyc(4);
    bus_wr(2'd2, 32'hFF);
    bus_wr(2'd0, 32'h3C);
    chk("pre_reset_irq", {31'h0, irq0}, 32'h1);
    chk("pre_reset_out", {24'h0, op0}, 32'h3C);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rd", rd0, 32'h0);
    chk("async_out0", {24'h0, op0}, 32'h00);
    chk("async_out1", {24'h0, op1}, 32'h5A);
    chk("async_irq", {31'h0, irq0 | irq1}, 32'h0);
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    address = 2'd3;
    cyc(8);
    chk("rearm_no_edge0", rd0, 32'h0);
    chk("rearm_no_edge1", rd1, 32'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) in_port = 8'($urandom);
      chipselect = 1'($urandom_range(1));
      write_n = 1'($urandom_range(1));
      address = 2'($urandom_range(3));
      writedata = $urandom;
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
